// File: rtl/epwm_cfg_pkg.sv
// rtl/epwm_cfg_pkg.sv - shared types and register map for the epwm configuration sequencer
package epwm_cfg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WADDR,
      ST_WRESP,
      ST_RADDR,
      ST_RDATA,
      ST_DONE
   } state_e;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_RESP     = 2'd1,
      ERR_MISMATCH = 2'd2,
      ERR_TIMEOUT  = 2'd3
   } err_code_e;

   localparam logic [3:0] OFS_CTRL     = 4'h0;
   localparam logic [3:0] OFS_PERIOD   = 4'h4;
   localparam logic [3:0] OFS_DUTY     = 4'h8;
   localparam logic [3:0] OFS_DEADBAND = 4'hC;

   // Entry i is the offset of the i-th access; it also matches word i of req_data.
   localparam logic [3:0][3:0] WR_ORDER = {OFS_CTRL, OFS_DEADBAND, OFS_DUTY, OFS_PERIOD};

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   function automatic logic resp_bad(input logic [1:0] resp);
      return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
   endfunction

endpackage

// File: rtl/epwm_cfg_rr_arb.sv
// rtl/epwm_cfg_rr_arb.sv - 2-way round-robin arbiter
// ptr_q names the requester preferred on a tie; it moves away from each winner.
module epwm_cfg_rr_arb (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   logic ptr_q, ptr_d;

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance && (grant != 2'b00)) begin
         ptr_d = grant[0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/epwm_cfg_sequencer.sv
// rtl/epwm_cfg_sequencer.sv - AXI4-Lite master loading a 4-register epwm configuration
// Arbitrates two requesters, writes PERIOD/DUTY/DEADBAND/CTRL, optionally reads back and compares.
module epwm_cfg_sequencer
   import epwm_cfg_pkg::*;
#(
   parameter int                      C_ADDR_WIDTH = 4,
   parameter int                      C_DATA_WIDTH = 32,
   parameter logic [C_ADDR_WIDTH-1:0] C_BASE_ADDR  = '0,
   parameter int                      C_VERIFY     = 1,
   parameter int                      C_TIMEOUT    = 255
) (
   input  logic                                ACLK,
   input  logic                                ARESET,
   input  logic [1:0]                          req_valid,
   input  logic [1:0][4*C_DATA_WIDTH-1:0]      req_data,
   output logic [1:0]                          req_ready,
   output logic                                done,
   output logic                                done_id,
   output logic                                err,
   output logic [1:0]                          err_code,
   output logic                                busy,
   output logic [C_ADDR_WIDTH-1:0]             M_AXI_AWADDR,
   output logic [2:0]                          M_AXI_AWPROT,
   output logic                                M_AXI_AWVALID,
   input  logic                                M_AXI_AWREADY,
   output logic [C_DATA_WIDTH-1:0]             M_AXI_WDATA,
   output logic [C_DATA_WIDTH/8-1:0]           M_AXI_WSTRB,
   output logic                                M_AXI_WVALID,
   input  logic                                M_AXI_WREADY,
   input  logic [1:0]                          M_AXI_BRESP,
   input  logic                                M_AXI_BVALID,
   output logic                                M_AXI_BREADY,
   output logic [C_ADDR_WIDTH-1:0]             M_AXI_ARADDR,
   output logic [2:0]                          M_AXI_ARPROT,
   output logic                                M_AXI_ARVALID,
   input  logic                                M_AXI_ARREADY,
   input  logic [C_DATA_WIDTH-1:0]             M_AXI_RDATA,
   input  logic [1:0]                          M_AXI_RRESP,
   input  logic                                M_AXI_RVALID,
   output logic                                M_AXI_RREADY
);

   localparam int              CW  = $clog2(C_TIMEOUT + 1);
   localparam logic [CW-1:0]   TMO = CW'(C_TIMEOUT);

   state_e                        state_q, state_d;
   logic [1:0]                    idx_q, idx_d;
   logic                          id_q, id_d;
   logic [3:0][C_DATA_WIDTH-1:0]  cfg_q, cfg_d;
   logic                          aw_done_q, aw_done_d;
   logic                          w_done_q, w_done_d;
   err_code_e                     ecode_q, ecode_d;
   logic [CW-1:0]                 cnt_q, cnt_d;

   logic [1:0] grant;
   logic       advance;
   logic       aw_fire, w_fire, tmo;
   logic [C_ADDR_WIDTH-1:0] reg_addr;

   epwm_cfg_rr_arb u_arb (
      .clk     (ACLK),
      .rst     (ARESET),
      .req     (req_valid),
      .advance (advance),
      .grant   (grant)
   );

   assign advance   = (state_q == ST_IDLE) && (req_valid != 2'b00);
   assign req_ready = advance ? grant : 2'b00;

   // Address and data come only from registered state, so they hold while VALID is up.
   assign reg_addr      = C_BASE_ADDR + C_ADDR_WIDTH'(WR_ORDER[idx_q]);
   assign M_AXI_AWADDR  = reg_addr;
   assign M_AXI_ARADDR  = reg_addr;
   assign M_AXI_WDATA   = cfg_q[idx_q];
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_WSTRB   = '1;
   assign M_AXI_AWVALID = (state_q == ST_WADDR) && !aw_done_q;
   assign M_AXI_WVALID  = (state_q == ST_WADDR) && !w_done_q;
   assign M_AXI_BREADY  = (state_q == ST_WRESP);
   assign M_AXI_ARVALID = (state_q == ST_RADDR);
   assign M_AXI_RREADY  = (state_q == ST_RDATA);

   assign done     = (state_q == ST_DONE);
   assign done_id  = done && id_q;
   assign err      = done && (ecode_q != ERR_NONE);
   assign err_code = done ? ecode_q : ERR_NONE;
   assign busy     = (state_q != ST_IDLE);

   assign aw_fire = M_AXI_AWVALID && M_AXI_AWREADY;
   assign w_fire  = M_AXI_WVALID && M_AXI_WREADY;
   assign tmo     = (cnt_q == TMO);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      id_d      = id_q;
      cfg_d     = cfg_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      ecode_d   = ecode_q;
      case (state_q)
         ST_IDLE: begin
            if (advance) begin
               id_d      = grant[1];
               cfg_d     = req_data[grant[1]];
               idx_d     = 2'd0;
               ecode_d   = ERR_NONE;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = ST_WADDR;
            end
         end
         ST_WADDR: begin
            aw_done_d = aw_done_q || aw_fire;
            w_done_d  = w_done_q || w_fire;
            if (aw_done_d && w_done_d) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = ST_WRESP;
            end else if (tmo) begin
               ecode_d = ERR_TIMEOUT;
               state_d = ST_DONE;
            end
         end
         ST_WRESP: begin
            if (M_AXI_BVALID) begin
               if (resp_bad(M_AXI_BRESP)) begin
                  ecode_d = ERR_RESP;
                  state_d = ST_DONE;
               end else if (idx_q == 2'd3) begin
                  idx_d   = 2'd0;
                  state_d = (C_VERIFY != 0) ? ST_RADDR : ST_DONE;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  state_d = ST_WADDR;
               end
            end else if (tmo) begin
               ecode_d = ERR_TIMEOUT;
               state_d = ST_DONE;
            end
         end
         ST_RADDR: begin
            if (M_AXI_ARREADY) begin
               state_d = ST_RDATA;
            end else if (tmo) begin
               ecode_d = ERR_TIMEOUT;
               state_d = ST_DONE;
            end
         end
         ST_RDATA: begin
            if (M_AXI_RVALID) begin
               if (resp_bad(M_AXI_RRESP)) begin
                  ecode_d = ERR_RESP;
                  state_d = ST_DONE;
               end else if (M_AXI_RDATA != cfg_q[idx_q]) begin
                  ecode_d = ERR_MISMATCH;
                  state_d = ST_DONE;
               end else if (idx_q == 2'd3) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  state_d = ST_RADDR;
               end
            end else if (tmo) begin
               ecode_d = ERR_TIMEOUT;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      cnt_d = ((state_d != state_q) || (state_q == ST_IDLE)) ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q   <= ST_IDLE;
         idx_q     <= 2'd0;
         id_q      <= 1'b0;
         cfg_q     <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         ecode_q   <= ERR_NONE;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         id_q      <= id_d;
         cfg_q     <= cfg_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         ecode_q   <= ecode_d;
         cnt_q     <= cnt_d;
      end
   end

endmodule
